alarm_ctrl_fsm: RTL and testbench

Mode controller that sequences the minutes/seconds BCD counter: it turns 1 Hz and 2 Hz tick pulses plus debounced button and switch inputs into the counter's single-cycle step enable, direction, adjust and select controls. It also holds an alarm setpoint, compares it against the counter's live digits, and drives an alarm/blink indication. It sits between the clock divider, debouncers and counter, and feeds the display mux.

---
 rtl/alarm_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_alarm_ctrl_fsm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | alarm_ctrl_fsm: mode/alarm sequencer for the mm:ss BCD counter (TIMER_EXPIRY_EN adds |
// | countdown-expiry ringing).                                              Rev 1.0      |
// +--------------------------------------------------------------------------------------+
module alarm_ctrl_fsm #(
  parameter int unsigned RING_TIMEOUT = 60
) (
  input  logic        clk_used,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        tick_2hz,
  input  logic        pause_pulse,
  input  logic        dir_pulse,
  input  logic        aset_pulse,
  input  logic        clr_pulse,
  input  logic        adj_sw,
  input  logic        sel_sw,
  input  logic [15:0] cnt_digits,
  output logic        cnt_rst,
  output logic        is_running,
  output logic        is_fwd_or_bkwd,
  output logic        adj,
  output logic        sel,
  output logic [15:0] alarm_digits,
  output logic        alarm_armed,
  output logic        alarm_active,
  output logic        blink
);

  localparam logic [2:0] c_PAUSED = 3'd0;
  localparam logic [2:0] c_RUN    = 3'd1;
  localparam logic [2:0] c_ADJUST = 3'd2;
  localparam logic [2:0] c_ASET   = 3'd3;
  localparam logic [2:0] c_RING   = 3'd4;
  localparam logic [7:0] c_RING_LAST = 8'(RING_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic        run_flag_q, run_flag_d;
  logic        step_chk_q, step_chk_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic        cnt_rst_q, cnt_rst_d;
  logic        is_running_q, is_running_d;
  logic        fwd_q, fwd_d;
  logic        adj_q, adj_d;
  logic        sel_q, sel_d;
  logic [15:0] alarm_digits_q, alarm_digits_d;
  logic        armed_q, armed_d;
  logic        active_q, active_d;
  logic        blink_q, blink_d;

  logic        w_step, w_clr, w_dir_tgl, w_sp_tick, w_blink_tgl;
  logic        w_bcd_ok, w_match, w_expire;
  logic [2:0]  w_ret;
  logic [7:0]  w_field, w_field_inc;
  logic [3:0]  w_top_max;
  logic [15:0] w_sp_next;

  assign w_ret = run_flag_q ? c_RUN : c_PAUSED;

  // Match is evaluated once the counter has absorbed the previous step
  assign w_bcd_ok = (cnt_digits[15:12] <= 4'd9) && (cnt_digits[11:8] <= 4'd9) &&
                    (cnt_digits[7:4]   <= 4'd9) && (cnt_digits[3:0]  <= 4'd9);
  assign w_match  = step_chk_q && armed_q && w_bcd_ok && (cnt_digits == alarm_digits_q);
`ifdef TIMER_EXPIRY_EN
  assign w_expire = step_chk_q && !fwd_q && (cnt_digits == 16'h0000);
`else
  assign w_expire = 1'b0;
`endif

  // Setpoint field increment: seconds wrap 59->00, minutes 99->00, no carry
  assign w_field   = sel_sw ? alarm_digits_q[7:0] : alarm_digits_q[15:8];
  assign w_top_max = sel_sw ? 4'd5 : 4'd9;
  always_comb begin
    if (w_field[3:0] != 4'd9)
      w_field_inc = {w_field[7:4], w_field[3:0] + 4'd1};
    else if (w_field[7:4] == w_top_max)
      w_field_inc = 8'h00;
    else
      w_field_inc = {w_field[7:4] + 4'd1, 4'h0};
  end
  assign w_sp_next = sel_sw ? {alarm_digits_q[15:8], w_field_inc}
                            : {w_field_inc, alarm_digits_q[7:0]};

  always_ff @(posedge clk_used) begin
    if (rst) begin
      state_q        <= c_PAUSED;
      run_flag_q     <= 1'b0;
      step_chk_q     <= 1'b0;
      ring_cnt_q     <= 8'd0;
      cnt_rst_q      <= 1'b1;
      is_running_q   <= 1'b0;
      fwd_q          <= 1'b1;
      adj_q          <= 1'b0;
      sel_q          <= 1'b0;
      alarm_digits_q <= 16'h0000;
      armed_q        <= 1'b0;
      active_q       <= 1'b0;
      blink_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_flag_q     <= run_flag_d;
      step_chk_q     <= step_chk_d;
      ring_cnt_q     <= ring_cnt_d;
      cnt_rst_q      <= cnt_rst_d;
      is_running_q   <= is_running_d;
      fwd_q          <= fwd_d;
      adj_q          <= adj_d;
      sel_q          <= sel_d;
      alarm_digits_q <= alarm_digits_d;
      armed_q        <= armed_d;
      active_q       <= active_d;
      blink_q        <= blink_d;
    end
  end

  // Any state change in a cycle swallows that cycle's tick
  always_comb begin
    state_d     = state_q;
    run_flag_d  = run_flag_q;
    w_step      = 1'b0;
    w_clr       = 1'b0;
    w_dir_tgl   = 1'b0;
    w_sp_tick   = 1'b0;
    w_blink_tgl = 1'b0;
    case (state_q)
      c_PAUSED: begin
        if (adj_sw) begin
          state_d    = c_ADJUST;
          run_flag_d = 1'b0;
        end else if (pause_pulse) begin
          state_d = c_RUN;
        end else if (aset_pulse) begin
          state_d    = c_ASET;
          run_flag_d = 1'b0;
        end else if (clr_pulse) begin
          w_clr = 1'b1;
        end else if (dir_pulse) begin
          w_dir_tgl = 1'b1;
        end
      end
      c_RUN: begin
        if (w_match || w_expire) begin
          state_d    = c_RING;
          run_flag_d = !w_expire;
        end else if (adj_sw) begin
          state_d    = c_ADJUST;
          run_flag_d = 1'b1;
        end else if (pause_pulse) begin
          state_d = c_PAUSED;
        end else if (aset_pulse) begin
          state_d    = c_ASET;
          run_flag_d = 1'b1;
        end else begin
          w_step = tick_1hz;
        end
      end
      c_ADJUST: begin
        if (!adj_sw) state_d = w_ret;
        else         w_step  = tick_2hz;
      end
      c_ASET: begin
        if (aset_pulse) begin
          state_d = w_ret;
        end else begin
          w_sp_tick   = tick_2hz;
          w_blink_tgl = tick_2hz;
        end
      end
      c_RING: begin
        if ((tick_1hz && (ring_cnt_q == c_RING_LAST)) || pause_pulse || aset_pulse) begin
          state_d = w_ret;
        end else begin
          w_step      = tick_1hz && run_flag_q;
          w_blink_tgl = tick_2hz;
        end
      end
      default: state_d = c_PAUSED;
    endcase
  end

  always_comb begin
    is_running_d   = w_step;
    cnt_rst_d      = w_clr;
    fwd_d          = fwd_q ^ w_dir_tgl;
    adj_d          = adj_q;
    sel_d          = sel_q;
    alarm_digits_d = w_sp_tick ? w_sp_next : alarm_digits_q;
    armed_d        = armed_q;
    active_d       = active_q;
    blink_d        = blink_q ^ w_blink_tgl;
    step_chk_d     = is_running_q && (state_q == c_RUN);
    ring_cnt_d     = (state_q == c_RING) ? ring_cnt_q + {7'd0, tick_1hz} : 8'd0;
    if (w_step) begin
      adj_d = (state_q == c_ADJUST);
      if (state_q == c_ADJUST) sel_d = sel_sw;
    end
    if ((state_q == c_ASET) && (state_d != c_ASET)) begin
      armed_d = 1'b1;
      blink_d = 1'b0;
    end
    if ((state_q == c_RING) && (state_d != c_RING)) begin
      armed_d  = 1'b0;
      active_d = 1'b0;
      blink_d  = 1'b0;
    end
    if ((state_q != c_RING) && (state_d == c_RING)) active_d = 1'b1;
  end

  assign cnt_rst        = cnt_rst_q;
  assign is_running     = is_running_q;
  assign is_fwd_or_bkwd = fwd_q;
  assign adj            = adj_q;
  assign sel            = sel_q;
  assign alarm_digits   = alarm_digits_q;
  assign alarm_armed    = armed_q;
  assign alarm_active   = active_q;
  assign blink          = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | tb_alarm_ctrl_fsm: scenario bench for alarm_ctrl_fsm with a behavioural mm:ss model. |
// | Rev 1.0                                                                              |
// +--------------------------------------------------------------------------------------+
module tb_alarm_ctrl_fsm;

  logic        clk_used = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1hz = 1'b0, tick_2hz = 1'b0;
  logic        pause_pulse = 1'b0, dir_pulse = 1'b0, aset_pulse = 1'b0, clr_pulse = 1'b0;
  logic        adj_sw = 1'b0, sel_sw = 1'b0;
  logic [15:0] cnt_digits = 16'h0000;
  logic        cnt_rst, is_running, is_fwd_or_bkwd, adj, sel;
  logic [15:0] alarm_digits;
  logic        alarm_armed, alarm_active, blink;

`ifdef TIMER_EXPIRY_EN
  localparam bit c_EXP = 1'b1;
`else
  localparam bit c_EXP = 1'b0;
`endif

  typedef struct packed { logic adj; logic sel; logic fwd; } step_t;
  step_t       sb_step[$];
  logic [15:0] sb_sp[$];
  logic        sb_alarm[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  alarm_ctrl_fsm #(.RING_TIMEOUT(60)) dut (
    .clk_used(clk_used), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_pulse(pause_pulse), .dir_pulse(dir_pulse), .aset_pulse(aset_pulse),
    .clr_pulse(clr_pulse), .adj_sw(adj_sw), .sel_sw(sel_sw), .cnt_digits(cnt_digits),
    .cnt_rst(cnt_rst), .is_running(is_running), .is_fwd_or_bkwd(is_fwd_or_bkwd),
    .adj(adj), .sel(sel), .alarm_digits(alarm_digits), .alarm_armed(alarm_armed),
    .alarm_active(alarm_active), .blink(blink)
  );

  always #5 clk_used = ~clk_used;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_used);
      #1;
    end
  endtask

  // Counter model: mm:ss as total seconds
  function automatic logic [15:0] cnt_step(input logic [15:0] d, input bit up);
    int t;
    t = (d[15:12] * 10 + d[11:8]) * 60 + d[7:4] * 10 + d[3:0];
    t = up ? (t + 1) % 6000 : (t + 5999) % 6000;
    return {4'((t / 60) / 10), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'((t % 60) % 10)};
  endfunction

  function automatic logic [15:0] sp_inc(input logic [15:0] d, input bit secs);
    int m, s;
    m = d[15:12] * 10 + d[11:8];
    s = d[7:4] * 10 + d[3:0];
    if (secs) s = (s + 1) % 60;
    else      m = (m + 1) % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_cmp++; if (cnt_rst !== 1'b1) begin n_bad++; $display("FAIL rst_cnt_rst: got %b want 1", cnt_rst); end
    n_cmp++; if (is_running !== 1'b0) begin n_bad++; $display("FAIL rst_is_running: got %b want 0", is_running); end
    n_cmp++; if (is_fwd_or_bkwd !== 1'b1) begin n_bad++; $display("FAIL rst_fwd: got %b want 1", is_fwd_or_bkwd); end
    n_cmp++; if ({adj, sel} !== 2'b00) begin n_bad++; $display("FAIL rst_adj_sel: got %b want 00", {adj, sel}); end
    n_cmp++; if (alarm_digits !== 16'h0000) begin n_bad++; $display("FAIL rst_alarm_digits: got %h want 0000", alarm_digits); end
    n_cmp++; if ({alarm_armed, alarm_active, blink} !== 3'b000) begin n_bad++; $display("FAIL rst_alarm_flags: got %b want 000", {alarm_armed, alarm_active, blink}); end
    rst = 1'b0;
    cyc(1);
    n_cmp++; if (cnt_rst !== 1'b0) begin n_bad++; $display("FAIL rst_release_cnt_rst: got %b want 0", cnt_rst); end
  endtask

  task automatic test_run();
    step_t e;
    pause_pulse = 1'b1; cyc(1); pause_pulse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick_1hz = 1'b1;
      sb_step.push_back('{adj: 1'b0, sel: 1'b0, fwd: 1'b1});
      cyc(1);
      tick_1hz = 1'b0;
      e = sb_step.pop_front();
      n_cmp++; if (is_running !== 1'b1) begin n_bad++; $display("FAIL run_pulse[%0d]: got %b want 1", k, is_running); end
      n_cmp++; if ({adj, is_fwd_or_bkwd} !== {e.adj, e.fwd}) begin n_bad++; $display("FAIL run_adj_fwd[%0d]: got %b want %b", k, {adj, is_fwd_or_bkwd}, {e.adj, e.fwd}); end
      cyc(1);
      n_cmp++; if (is_running !== 1'b0) begin n_bad++; $display("FAIL run_pulse_width[%0d]: got %b want 0", k, is_running); end
      cnt_digits = cnt_step(cnt_digits, 1'b1);
      cyc(1);
    end
    dir_pulse = 1'b1; cyc(1); dir_pulse = 1'b0;
    n_cmp++; if (is_fwd_or_bkwd !== 1'b1) begin n_bad++; $display("FAIL run_dir_ignored: got %b want 1", is_fwd_or_bkwd); end
    clr_pulse = 1'b1; cyc(1); clr_pulse = 1'b0;
    n_cmp++; if (cnt_rst !== 1'b0) begin n_bad++; $display("FAIL run_clr_ignored: got %b want 0", cnt_rst); end
  endtask

  task automatic test_adjust();
    step_t e;
    cnt_digits = 16'h1234;
    adj_sw = 1'b1; sel_sw = 1'b0;
    cyc(1);
    for (int k = 0; k < 2; k++) begin
      sel_sw = (k == 1);
      tick_2hz = 1'b1;
      sb_step.push_back('{adj: 1'b1, sel: sel_sw, fwd: 1'b1});
      cyc(1);
      tick_2hz = 1'b0;
      e = sb_step.pop_front();
      n_cmp++; if ({is_running, adj, sel} !== {1'b1, e.adj, e.sel}) begin n_bad++; $display("FAIL adj_step[%0d]: got %b want %b", k, {is_running, adj, sel}, {1'b1, e.adj, e.sel}); end
      cyc(1);
    end
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    n_cmp++; if (is_running !== 1'b0) begin n_bad++; $display("FAIL adj_1hz_ignored: got %b want 0", is_running); end
    adj_sw = 1'b0; cyc(1);
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    n_cmp++; if ({is_running, adj} !== 2'b10) begin n_bad++; $display("FAIL adj_back_to_run: got %b want 10", {is_running, adj}); end
    cyc(1);
  endtask

  task automatic test_aset();
    logic [15:0] sp_model, exp_sp;
    sp_model = 16'h0000;
    aset_pulse = 1'b1; cyc(1); aset_pulse = 1'b0;
    for (int i = 0; i < 66; i++) begin
      sel_sw = (i >= 5);
      tick_2hz = 1'b1;
      sp_model = sp_inc(sp_model, sel_sw);
      sb_sp.push_back(sp_model);
      cyc(1);
      tick_2hz = 1'b0;
      exp_sp = sb_sp.pop_front();
      n_cmp++; if (alarm_digits !== exp_sp) begin n_bad++; $display("FAIL aset_digits[%0d]: got %h want %h", i, alarm_digits, exp_sp); end
      n_cmp++; if (is_running !== 1'b0) begin n_bad++; $display("FAIL aset_no_step[%0d]: got %b want 0", i, is_running); end
      n_cmp++; if (blink !== ((i % 2) == 0)) begin n_bad++; $display("FAIL aset_blink[%0d]: got %b want %b", i, blink, (i % 2) == 0); end
      cyc(1);
    end
    aset_pulse = 1'b1; cyc(1); aset_pulse = 1'b0;
    n_cmp++; if ({alarm_digits, alarm_armed, blink} !== {16'h0501, 1'b1, 1'b0}) begin n_bad++; $display("FAIL aset_exit: got %h/%b/%b want 0501/1/0", alarm_digits, alarm_armed, blink); end
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    n_cmp++; if (is_running !== 1'b1) begin n_bad++; $display("FAIL aset_return_run: got %b want 1", is_running); end
    cyc(1);
  endtask

  task automatic test_match();
    logic exp_a;
    do_reset();
    cnt_digits = 16'h0000;
    aset_pulse = 1'b1; cyc(1); aset_pulse = 1'b0;
    sel_sw = 1'b1;
    repeat (3) begin tick_2hz = 1'b1; cyc(1); tick_2hz = 1'b0; cyc(1); end
    aset_pulse = 1'b1; cyc(1); aset_pulse = 1'b0;
    n_cmp++; if ({alarm_digits, alarm_armed} !== {16'h0003, 1'b1}) begin n_bad++; $display("FAIL match_setpoint: got %h/%b want 0003/1", alarm_digits, alarm_armed); end
    pause_pulse = 1'b1; cyc(1); pause_pulse = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick_1hz = 1'b1;
      sb_alarm.push_back(k == 3);
      cyc(1);
      tick_1hz = 1'b0;
      n_cmp++; if (is_running !== 1'b1) begin n_bad++; $display("FAIL match_step[%0d]: got %b want 1", k, is_running); end
      cyc(1);
      cnt_digits = cnt_step(cnt_digits, 1'b1);
      n_cmp++; if (alarm_active !== 1'b0) begin n_bad++; $display("FAIL match_early[%0d]: got %b want 0", k, alarm_active); end
      cyc(1);
      exp_a = sb_alarm.pop_front();
      n_cmp++; if (alarm_active !== exp_a) begin n_bad++; $display("FAIL match_ring[%0d]: got %b want %b", k, alarm_active, exp_a); end
    end
    pause_pulse = 1'b1; cyc(1); pause_pulse = 1'b0;
    n_cmp++; if ({alarm_active, alarm_armed} !== 2'b00) begin n_bad++; $display("FAIL match_ack: got %b want 00", {alarm_active, alarm_armed}); end
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    n_cmp++; if (is_running !== 1'b1) begin n_bad++; $display("FAIL match_ack_run: got %b want 1", is_running); end
    cyc(1);
    cnt_digits = cnt_step(cnt_digits, 1'b1);
    cyc(1);
  endtask

  task automatic test_timeout();
    aset_pulse = 1'b1; cyc(1); aset_pulse = 1'b0;
    sel_sw = 1'b1;
    repeat (2) begin tick_2hz = 1'b1; cyc(1); tick_2hz = 1'b0; cyc(1); end
    aset_pulse = 1'b1; cyc(1); aset_pulse = 1'b0;
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    cyc(1);
    cnt_digits = cnt_step(cnt_digits, 1'b1);
    cyc(1);
    n_cmp++; if (alarm_active !== 1'b1) begin n_bad++; $display("FAIL tmo_ring: got %b want 1 (cnt %h sp %h)", alarm_active, cnt_digits, alarm_digits); end
    for (int i = 1; i <= 60; i++) begin
      tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
      if (i == 1) begin
        n_cmp++; if (is_running !== 1'b1) begin n_bad++; $display("FAIL tmo_ring_step: got %b want 1", is_running); end
      end
      if (i == 59) begin
        n_cmp++; if (alarm_active !== 1'b1) begin n_bad++; $display("FAIL tmo_still_ring: got %b want 1", alarm_active); end
      end
      if (i == 60) begin
        n_cmp++; if ({alarm_active, alarm_armed, blink} !== 3'b000) begin n_bad++; $display("FAIL tmo_clear: got %b want 000", {alarm_active, alarm_armed, blink}); end
      end
      cyc(2);
    end
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    n_cmp++; if (is_running !== 1'b1) begin n_bad++; $display("FAIL tmo_back_run: got %b want 1", is_running); end
    cyc(1);
  endtask

  task automatic test_expiry();
    logic exp_run;
    do_reset();
    dir_pulse = 1'b1; cyc(1); dir_pulse = 1'b0;
    n_cmp++; if (is_fwd_or_bkwd !== 1'b0) begin n_bad++; $display("FAIL exp_dir_toggle: got %b want 0", is_fwd_or_bkwd); end
    cnt_digits = 16'h0002;
    pause_pulse = 1'b1; cyc(1); pause_pulse = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
      n_cmp++; if ({is_running, is_fwd_or_bkwd} !== 2'b10) begin n_bad++; $display("FAIL exp_step[%0d]: got %b want 10", k, {is_running, is_fwd_or_bkwd}); end
      cyc(1);
      cnt_digits = cnt_step(cnt_digits, 1'b0);
      cyc(1);
      n_cmp++; if (alarm_active !== ((k == 2) && c_EXP)) begin n_bad++; $display("FAIL exp_ring[%0d]: got %b want %b", k, alarm_active, (k == 2) && c_EXP); end
    end
`ifdef TIMER_EXPIRY_EN
    pause_pulse = 1'b1; cyc(1); pause_pulse = 1'b0;
    n_cmp++; if (alarm_active !== 1'b0) begin n_bad++; $display("FAIL exp_ack: got %b want 0", alarm_active); end
    exp_run = 1'b0;
`else
    exp_run = 1'b1;
`endif
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    n_cmp++; if (is_running !== exp_run) begin n_bad++; $display("FAIL exp_after: got %b want %b", is_running, exp_run); end
    cyc(1);
  endtask

  task automatic test_rst_in_ring();
    do_reset();
    cnt_digits = 16'h0000;
    aset_pulse = 1'b1; cyc(1); aset_pulse = 1'b0;
    sel_sw = 1'b1;
    tick_2hz = 1'b1; cyc(1); tick_2hz = 1'b0; cyc(1);
    aset_pulse = 1'b1; cyc(1); aset_pulse = 1'b0;
    pause_pulse = 1'b1; cyc(1); pause_pulse = 1'b0;
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    cyc(1);
    cnt_digits = 16'h0001;
    cyc(1);
    n_cmp++; if (alarm_active !== 1'b1) begin n_bad++; $display("FAIL rring_ring: got %b want 1", alarm_active); end
    tick_2hz = 1'b1; cyc(1); tick_2hz = 1'b0;
    n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL rring_blink: got %b want 1", blink); end
    rst = 1'b1; cyc(1);
    n_cmp++; if ({cnt_rst, is_running, is_fwd_or_bkwd, adj, sel} !== 5'b10100) begin n_bad++; $display("FAIL rring_ctrl: got %b want 10100", {cnt_rst, is_running, is_fwd_or_bkwd, adj, sel}); end
    n_cmp++; if ({alarm_digits, alarm_armed, alarm_active, blink} !== 19'd0) begin n_bad++; $display("FAIL rring_alarm: got %h/%b want 0000/000", alarm_digits, {alarm_armed, alarm_active, blink}); end
    rst = 1'b0; cyc(1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    cnt_digits = 16'h4242;
    pause_pulse = 1'b1; dir_pulse = 1'b1; cyc(1); pause_pulse = 1'b0; dir_pulse = 1'b0;
    n_cmp++; if (is_fwd_or_bkwd !== 1'b1) begin n_bad++; $display("FAIL b2b_dir_dropped: got %b want 1", is_fwd_or_bkwd); end
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    n_cmp++; if (is_running !== 1'b1) begin n_bad++; $display("FAIL b2b_run: got %b want 1", is_running); end
    cyc(1);
    pause_pulse = 1'b1; cyc(1); pause_pulse = 1'b0;
    clr_pulse = 1'b1; dir_pulse = 1'b1; cyc(1); clr_pulse = 1'b0; dir_pulse = 1'b0;
    n_cmp++; if ({cnt_rst, is_fwd_or_bkwd} !== 2'b11) begin n_bad++; $display("FAIL b2b_clr: got %b want 11", {cnt_rst, is_fwd_or_bkwd}); end
    cyc(1);
    n_cmp++; if (cnt_rst !== 1'b0) begin n_bad++; $display("FAIL b2b_clr_width: got %b want 0", cnt_rst); end
    adj_sw = 1'b1; pause_pulse = 1'b1; cyc(1); pause_pulse = 1'b0;
    tick_2hz = 1'b1; cyc(1); tick_2hz = 1'b0;
    n_cmp++; if ({is_running, adj} !== 2'b11) begin n_bad++; $display("FAIL b2b_adj_wins: got %b want 11", {is_running, adj}); end
    cyc(1);
    adj_sw = 1'b0; cyc(1);
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    n_cmp++; if (is_running !== 1'b0) begin n_bad++; $display("FAIL b2b_back_paused: got %b want 0", is_running); end
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_run();
    test_adjust();
    test_aset();
    test_match();
    test_timeout();
    test_expiry();
    test_rst_in_ring();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
